// File: rtl/jtcps1_sndcmd.sv
// CPS1 main-CPU sound command latches: decodes 68000 byte writes into snd_latch0/snd_latch1.
// Define JTCPS1_SNDQUEUE_EN to add a pending-command FIFO behind latch 0.
module jtcps1_sndcmd #(
   parameter int QW = 2
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          snd_cs,
   input  logic          cpu_rnw,
   input  logic [1:0]    cpu_dsn,
   input  logic          cpu_a3,
   input  logic [15:0]   cpu_dout,
   input  logic          latch0_rd,
   output logic [7:0]    snd_latch0,
   output logic [7:0]    snd_latch1,
   output logic [QW-1:0] queue_lvl,
   output logic          overflow
);

   logic wr_s;
   logic wr_l_r;
   logic wr_ev_s;
   logic wr0_s;
   logic wr1_s;
   logic unused_s;

   assign wr_s    = snd_cs & ~cpu_rnw & ~cpu_dsn[0];
   assign wr_ev_s = wr_s & ~wr_l_r;
   assign wr0_s   = wr_ev_s & ~cpu_a3;
   assign wr1_s   = wr_ev_s & cpu_a3;

   // Write strobe history for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_l_r <= 1'b0;
      end else begin
         wr_l_r <= wr_s;
      end
   end

   // Latch 1 (fade byte), never queued
   always_ff @(posedge clk) begin
      if (rst) begin
         snd_latch1 <= 8'hFF;
      end else if (wr1_s) begin
         snd_latch1 <= cpu_dout[7:0];
      end else begin
         snd_latch1 <= snd_latch1;
      end
   end

`ifdef JTCPS1_SNDQUEUE_EN
   localparam int             DEPTH = 2**QW - 1;
   localparam logic [QW-1:0]  ZERO  = {QW{1'b0}};
   localparam logic [QW-1:0]  ONE   = {{(QW-1){1'b0}}, 1'b1};
   localparam logic [QW-1:0]  LAST  = QW'(DEPTH - 1);
   localparam logic [QW-1:0]  FULL  = QW'(DEPTH);

   logic [7:0]    fifo_r [DEPTH];
   logic [QW-1:0] wptr_r;
   logic [QW-1:0] rptr_r;
   logic          rd_l_r;
   logic          seen_r;
   logic          rd_ev_s;
   logic          empty_s;
   logic          full_s;
   logic          adv_s;
   logic          direct_s;
   logic          push_s;
   logic          drop_s;

   // FIFO depth need not be a power of two, so wrap explicitly
   function automatic logic [QW-1:0] next_ptr(input logic [QW-1:0] p);
      return (p == LAST) ? ZERO : p + ONE;
   endfunction

   assign rd_ev_s  = latch0_rd & ~rd_l_r;
   assign empty_s  = (queue_lvl == ZERO);
   assign full_s   = (queue_lvl == FULL);
   assign adv_s    = seen_r & ~empty_s;
   assign direct_s = wr0_s & empty_s & seen_r;
   assign push_s   = wr0_s & ~full_s & ~direct_s;
   assign drop_s   = wr0_s & full_s;
   assign unused_s = ^cpu_dout[15:8];

   // Pending command storage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) fifo_r[i] <= 8'h00;
      end else if (push_s) begin
         fifo_r[wptr_r] <= cpu_dout[7:0];
      end else begin
         fifo_r[wptr_r] <= fifo_r[wptr_r];
      end
   end

   // Latch 0 presentation, queue pointers, level, seen and overflow flags
   always_ff @(posedge clk) begin
      if (rst) begin
         snd_latch0 <= 8'hFF;
         wptr_r     <= ZERO;
         rptr_r     <= ZERO;
         queue_lvl  <= ZERO;
         rd_l_r     <= 1'b0;
         seen_r     <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         rd_l_r <= latch0_rd;
         if (push_s) wptr_r <= next_ptr(wptr_r);
         if (adv_s) begin
            snd_latch0 <= fifo_r[rptr_r];
            rptr_r     <= next_ptr(rptr_r);
         end else if (direct_s) begin
            snd_latch0 <= cpu_dout[7:0];
         end
         case ({push_s, adv_s})
            2'b10:   queue_lvl <= queue_lvl + ONE;
            2'b01:   queue_lvl <= queue_lvl - ONE;
            default: queue_lvl <= queue_lvl;
         endcase
         // A read landing with an advance marks the new value as already seen
         if (rd_ev_s) begin
            seen_r <= 1'b1;
         end else if (adv_s | direct_s) begin
            seen_r <= 1'b0;
         end
         if (drop_s) overflow <= 1'b1;
      end
   end
`else
   assign unused_s  = ^{cpu_dout[15:8], latch0_rd};
   assign queue_lvl = {QW{1'b0}};
   assign overflow  = 1'b0;

   // Latch 0 overwritten by every write event
   always_ff @(posedge clk) begin
      if (rst) begin
         snd_latch0 <= 8'hFF;
      end else if (wr0_s) begin
         snd_latch0 <= cpu_dout[7:0];
      end else begin
         snd_latch0 <= snd_latch0;
      end
   end
`endif

endmodule

// File: tb/tb_jtcps1_sndcmd.sv
// Self-checking bench for jtcps1_sndcmd; expected outputs follow JTCPS1_SNDQUEUE_EN.
module tb_jtcps1_sndcmd;
   localparam int QW = 2;
`ifdef JTCPS1_SNDQUEUE_EN
   localparam bit QEN = 1'b1;
`else
   localparam bit QEN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          snd_cs = 1'b0;
   logic          cpu_rnw = 1'b1;
   logic [1:0]    cpu_dsn = 2'b11;
   logic          cpu_a3 = 1'b0;
   logic [15:0]   cpu_dout = 16'h0000;
   logic          latch0_rd = 1'b0;
   logic [7:0]    snd_latch0;
   logic [7:0]    snd_latch1;
   logic [QW-1:0] queue_lvl;
   logic          overflow;

   typedef struct packed {
      logic [7:0]    l0;
      logic [7:0]    l1;
      logic [QW-1:0] lvl;
      logic          ovf;
   } obs_t;

   obs_t exp_q[$];
   obs_t got, e;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [7:0] m_l0, m_l1;
   logic       m_seen, m_ovf;
   logic [7:0] pend[$];

   jtcps1_sndcmd #(.QW(QW)) dut (
      .rst(rst), .clk(clk), .snd_cs(snd_cs), .cpu_rnw(cpu_rnw), .cpu_dsn(cpu_dsn),
      .cpu_a3(cpu_a3), .cpu_dout(cpu_dout), .latch0_rd(latch0_rd),
      .snd_latch0(snd_latch0), .snd_latch1(snd_latch1), .queue_lvl(queue_lvl),
      .overflow(overflow)
   );

   always #10 clk = ~clk;

   function automatic obs_t cur();
      return {snd_latch0, snd_latch1, queue_lvl, overflow};
   endfunction

   function automatic obs_t mk(input logic [7:0] l0, input logic [7:0] l1,
                               input int lvl, input logic ovf);
      return {l0, l1, QW'(lvl), ovf};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic bus_write(input logic a3, input logic [7:0] d, input int hold,
                            input logic [1:0] dsn, input logic rnw);
      @(negedge clk);
      snd_cs = 1'b1; cpu_rnw = rnw; cpu_dsn = dsn; cpu_a3 = a3; cpu_dout = {~d, d};
      repeat (hold) @(negedge clk);
      snd_cs = 1'b0; cpu_rnw = 1'b1; cpu_dsn = 2'b11;
      @(negedge clk);
   endtask

   task automatic z80_read(input int len);
      @(negedge clk);
      latch0_rd = 1'b1;
      repeat (len) @(negedge clk);
      latch0_rd = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      exp_q.push_back(mk(8'hFF, 8'hFF, 0, 1'b0));
      got = cur(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL reset: got l0=%h l1=%h lvl=%0d ovf=%b required l0=%h l1=%h lvl=%0d ovf=%b",
                  got.l0, got.l1, got.lvl, got.ovf, e.l0, e.l1, e.lvl, e.ovf);
      end
   endtask

   task automatic test_single_writes();
      do_reset();
      @(negedge clk);
      snd_cs = 1'b1; cpu_rnw = 1'b0; cpu_dsn = 2'b10; cpu_a3 = 1'b0; cpu_dout = 16'hED12;
      exp_q.push_back(mk(8'h12, 8'hFF, 0, 1'b0));
      @(negedge clk);
      got = cur(); e = exp_q.pop_front(); n_checks++;
      if (got.l0 !== e.l0) begin
         n_fail++;
         $display("FAIL write_latency: got l0=%h required l0=%h", got.l0, e.l0);
      end
      repeat (9) @(negedge clk);
      snd_cs = 1'b0; cpu_rnw = 1'b1; cpu_dsn = 2'b11;
      @(negedge clk);
      exp_q.push_back(mk(8'h12, 8'hFF, 0, 1'b0));
      exp_q.push_back(mk(8'h12, 8'h40, 0, 1'b0));
      exp_q.push_back(mk(8'h12, 8'h40, 0, 1'b0));
      exp_q.push_back(mk(8'h12, 8'h40, 0, 1'b0));
      for (int k = 0; k < 4; k++) begin
         case (k)
            1:       bus_write(1'b1, 8'h40, 10, 2'b10, 1'b0);
            2:       bus_write(1'b1, 8'h55, 3, 2'b01, 1'b0);
            3:       bus_write(1'b0, 8'h66, 3, 2'b10, 1'b1);
            default: ;
         endcase
         got = cur(); e = exp_q.pop_front(); n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL single_write[%0d]: got l0=%h l1=%h lvl=%0d ovf=%b required l0=%h l1=%h lvl=%0d ovf=%b",
                     k, got.l0, got.l1, got.lvl, got.ovf, e.l0, e.l1, e.lvl, e.ovf);
         end
      end
   endtask

   task automatic test_queue_fill();
      logic [7:0] rd_l0 [4];
      int         rd_lvl [4];
      rd_l0  = '{8'h02, 8'h03, 8'h04, 8'h04};
      rd_lvl = '{2, 1, 0, 0};
      do_reset();
      for (int i = 1; i <= 5; i++) bus_write(1'b0, 8'(i), 2, 2'b10, 1'b0);
      exp_q.push_back(QEN ? mk(8'h01, 8'hFF, 3, 1'b1) : mk(8'h05, 8'hFF, 0, 1'b0));
      got = cur(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL queue_fill: got l0=%h l1=%h lvl=%0d ovf=%b required l0=%h l1=%h lvl=%0d ovf=%b",
                  got.l0, got.l1, got.lvl, got.ovf, e.l0, e.l1, e.lvl, e.ovf);
      end
      for (int i = 0; i < 4; i++)
         exp_q.push_back(QEN ? mk(rd_l0[i], 8'hFF, rd_lvl[i], 1'b1) : mk(8'h05, 8'hFF, 0, 1'b0));
      for (int i = 0; i < 4; i++) begin
         z80_read(i + 1);
         got = cur(); e = exp_q.pop_front(); n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL queue_drain[%0d]: got l0=%h l1=%h lvl=%0d ovf=%b required l0=%h l1=%h lvl=%0d ovf=%b",
                     i, got.l0, got.l1, got.lvl, got.ovf, e.l0, e.l1, e.lvl, e.ovf);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus_write(1'b0, 8'h10, 1, 2'b10, 1'b0);
      bus_write(1'b0, 8'hAA, 1, 2'b10, 1'b0);
      exp_q.push_back(QEN ? mk(8'hAA, 8'hFF, 1, 1'b0) : mk(8'hBB, 8'hFF, 0, 1'b0));
      exp_q.push_back(mk(8'hBB, 8'h77, 0, 1'b0));
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         latch0_rd = 1'b1;
         @(negedge clk);
         latch0_rd = 1'b0;
         snd_cs = 1'b1; cpu_rnw = 1'b0; cpu_dsn = 2'b10;
         cpu_a3 = (k == 1); cpu_dout = (k == 1) ? 16'h0077 : 16'h00BB;
         @(negedge clk);
         snd_cs = 1'b0; cpu_rnw = 1'b1; cpu_dsn = 2'b11;
         @(negedge clk);
         got = cur(); e = exp_q.pop_front(); n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL pop_with_write[%0d]: got l0=%h l1=%h lvl=%0d ovf=%b required l0=%h l1=%h lvl=%0d ovf=%b",
                     k, got.l0, got.l1, got.lvl, got.ovf, e.l0, e.l1, e.lvl, e.ovf);
         end
      end
   endtask

   task automatic test_unseen();
      do_reset();
      bus_write(1'b0, 8'h10, 2, 2'b10, 1'b0);
      bus_write(1'b0, 8'h20, 2, 2'b10, 1'b0);
      exp_q.push_back(QEN ? mk(8'h10, 8'hFF, 1, 1'b0) : mk(8'h20, 8'hFF, 0, 1'b0));
      exp_q.push_back(mk(8'h20, 8'hFF, 0, 1'b0));
      exp_q.push_back(mk(8'hFF, 8'hFF, 0, 1'b0));
      exp_q.push_back(mk(8'hFF, 8'hFF, 0, 1'b0));
      for (int k = 0; k < 4; k++) begin
         case (k)
            1:       z80_read(1);
            2:       begin bus_write(1'b0, 8'h30, 1, 2'b10, 1'b0); do_reset(); end
            3:       z80_read(2);
            default: ;
         endcase
         got = cur(); e = exp_q.pop_front(); n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL unseen[%0d]: got l0=%h l1=%h lvl=%0d ovf=%b required l0=%h l1=%h lvl=%0d ovf=%b",
                     k, got.l0, got.l1, got.lvl, got.ovf, e.l0, e.l1, e.lvl, e.ovf);
         end
      end
   endtask

   task automatic test_random();
      int         op;
      logic [7:0] d;
      do_reset();
      m_l0 = 8'hFF; m_l1 = 8'hFF; m_seen = 1'b1; m_ovf = 1'b0; pend.delete();
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 3);
         d  = 8'($urandom);
         if (op == 3) begin
            z80_read($urandom_range(1, 3));
            m_seen = 1'b1;
            if (pend.size() > 0) begin
               m_l0 = pend.pop_front();
               m_seen = 1'b0;
            end
         end else if (op == 2) begin
            bus_write(1'b1, d, $urandom_range(1, 3), 2'b10, 1'b0);
            m_l1 = d;
         end else begin
            bus_write(1'b0, d, $urandom_range(1, 3), 2'b10, 1'b0);
            if (!QEN || (pend.size() == 0 && m_seen)) begin
               m_l0 = d;
               m_seen = 1'b0;
            end else if (pend.size() < 2**QW - 1) begin
               pend.push_back(d);
            end else begin
               m_ovf = 1'b1;
            end
         end
         exp_q.push_back(QEN ? mk(m_l0, m_l1, pend.size(), m_ovf) : mk(m_l0, m_l1, 0, 1'b0));
         got = cur(); e = exp_q.pop_front(); n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL random[%0d]: got l0=%h l1=%h lvl=%0d ovf=%b required l0=%h l1=%h lvl=%0d ovf=%b",
                     i, got.l0, got.l1, got.lvl, got.ovf, e.l0, e.l1, e.lvl, e.ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_writes();
      test_queue_fill();
      test_back_to_back();
      test_unseen();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
